// File: rtl/qar_mmio_initiator.sv
// Host-to-peripheral register initiator: sequences read, write and atomic set/clear-bit
// RMW commands onto the QAR word-addressed port, one command in flight, one response each.
module qar_mmio_initiator #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_ADDR = 11,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              write_en,
    output logic              read_en,
    output logic [ADDR_W-1:0] addr_word,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_t;

    localparam logic [1:0]        OP_RD    = 2'b00;
    localparam logic [1:0]        OP_WR    = 2'b01;
    localparam logic [1:0]        OP_SET   = 2'b10;
    localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(MAX_ADDR);
    localparam logic [1:0]        LAST_CNT = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                write_en_q, write_en_d;
    logic                read_en_q, read_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                rd_done;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mask_d      = mask_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        write_en_d  = 1'b0;
        read_en_d   = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    op_d        = cmd_op;
                    mask_d      = cmd_data;
                    if (cmd_addr > MAX_A) begin
                        // Rejected command: answer directly, never touch the bus.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else if (cmd_op == OP_WR) begin
                        state_d    = WR_ISSUE;
                        write_en_d = 1'b1;
                        addr_d     = cmd_addr;
                        wdata_d    = cmd_data;
                        res_d      = cmd_data;
                    end else begin
                        state_d   = RD_ISSUE;
                        read_en_d = 1'b1;
                        addr_d    = cmd_addr;
                    end
                end
            end
            RD_ISSUE: begin
                if (RD_LAT == 0) begin
                    rd_done = 1'b1;
                end else begin
                    state_d = RD_WAIT;
                    cnt_d   = '0;
                end
            end
            RD_WAIT: begin
                if (cnt_q == LAST_CNT) rd_done = 1'b1;
                else                   cnt_d   = cnt_q + 2'd1;
            end
            WR_ISSUE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = res_q;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Read data capture: plain reads respond, RMW ops schedule the modified write.
        if (rd_done) begin
            if (op_q == OP_RD) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = rdata;
            end else begin
                state_d    = WR_ISSUE;
                write_en_d = 1'b1;
                res_d      = rdata;
                wdata_d    = (op_q == OP_SET) ? (rdata | mask_q) : (rdata & ~mask_q);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            mask_q      <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            write_en_q  <= 1'b0;
            read_en_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mask_q      <= mask_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            write_en_q  <= write_en_d;
            read_en_q   <= read_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign write_en  = write_en_q;
    assign read_en   = read_en_q;
    assign addr_word = addr_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_qar_mmio_initiator.sv
// Directed bench for qar_mmio_initiator: table of commands against a register-file
// peripheral model (RD_LAT=1), plus stall and mid-RMW reset sequences.
module tb_qar_mmio_initiator;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              write_en;
    logic              read_en;
    logic [ADDR_W-1:0] addr_word;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    qar_mmio_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ADDR(11), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .write_en(write_en), .read_en(read_en), .addr_word(addr_word), .wdata(wdata),
        .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Peripheral model: 32 words, registered read data (one cycle latency).
    logic [DATA_W-1:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rdata = '0;
    end
    always @(posedge clk) begin
        if (write_en) mem[addr_word] <= wdata;
        if (read_en)  rdata <= mem[addr_word];
    end

    // Strobe monitor.
    int rd_cnt, wr_cnt, rsp_cnt, viol;
    logic prev_rd, prev_wr;
    initial begin
        rd_cnt = 0; wr_cnt = 0; rsp_cnt = 0; viol = 0; prev_rd = 0; prev_wr = 0;
    end
    always @(negedge clk) begin
        if (read_en) rd_cnt++;
        if (write_en) wr_cnt++;
        if (rsp_valid) rsp_cnt++;
        if ((read_en && write_en) || (read_en && prev_rd) || (write_en && prev_wr)) viol++;
        prev_rd = read_en;
        prev_wr = write_en;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp_rsp;
        logic              exp_err;
        int                exp_lat;
        int                exp_rd;
        int                exp_wr;
        logic [DATA_W-1:0] exp_mem;
    } vec_t;

    // Issue one command with rsp_ready high; returns response and latency from handshake.
    task automatic do_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data,
                          output logic [DATA_W-1:0] got_rsp, output logic got_err,
                          output int lat);
        @(negedge clk);
        rd_cnt = 0; wr_cnt = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got_rsp = rsp_data;
        got_err = rsp_err;
    endtask

    vec_t vecs[10];
    logic [DATA_W-1:0] g_rsp;
    logic              g_err;
    int                g_lat;
    int                stable_bad;
    int                t;

    initial begin
        vecs[0] = '{2'b01, 5'd0,  32'h0000_000F, 32'h0000_000F, 1'b0, 2, 0, 1, 32'h0000_000F};
        vecs[1] = '{2'b01, 5'd1,  32'h0000_0005, 32'h0000_0005, 1'b0, 2, 0, 1, 32'h0000_0005};
        vecs[2] = '{2'b00, 5'd1,  32'h0000_0000, 32'h0000_0005, 1'b0, 3, 1, 0, 32'h0000_0005};
        vecs[3] = '{2'b10, 5'd1,  32'h0000_000A, 32'h0000_0005, 1'b0, 4, 1, 1, 32'h0000_000F};
        vecs[4] = '{2'b11, 5'd1,  32'h0000_0003, 32'h0000_000F, 1'b0, 4, 1, 1, 32'h0000_000C};
        vecs[5] = '{2'b00, 5'd12, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 0, 32'h0000_0000};
        vecs[6] = '{2'b01, 5'd11, 32'h0000_1234, 32'h0000_1234, 1'b0, 2, 0, 1, 32'h0000_1234};
        vecs[7] = '{2'b10, 5'd13, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1, 0, 0, 32'h0000_0000};
        vecs[8] = '{2'b00, 5'd11, 32'h0000_0000, 32'h0000_1234, 1'b0, 3, 1, 0, 32'h0000_1234};
        vecs[9] = '{2'b01, 5'd31, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1, 0, 0, 32'h0000_0000};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        check("reset_outputs",
              {rsp_valid, rsp_err, write_en, read_en, busy, (rsp_data == 0), (addr_word == 0), (wdata == 0)},
              {5'b0, 3'b111});
        rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);

        // Table of commands.
        for (int i = 0; i < 10; i++) begin
            do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, g_rsp, g_err, g_lat);
            check($sformatf("v%0d_rsp_data", i), g_rsp, vecs[i].exp_rsp);
            check($sformatf("v%0d_rsp_err", i), g_err, vecs[i].exp_err);
            check($sformatf("v%0d_latency", i), g_lat, vecs[i].exp_lat);
            check($sformatf("v%0d_read_strobes", i), rd_cnt, vecs[i].exp_rd);
            check($sformatf("v%0d_write_strobes", i), wr_cnt, vecs[i].exp_wr);
            check($sformatf("v%0d_mem", i), mem[vecs[i].addr], vecs[i].exp_mem);
        end

        // Response stall: rsp_ready low for 5 cycles with another command waiting.
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 5'd1; cmd_data = '0;
        @(negedge clk);
        cmd_op = 2'b01; cmd_addr = 5'd2; cmd_data = 32'h77;
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("stall_rsp_arrives", rsp_valid, 1);
        stable_bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (!rsp_valid || rsp_data != 32'hC || cmd_ready || !busy) stable_bad++;
            @(negedge clk);
        end
        check("stall_stable_cycles_bad", stable_bad, 0);
        check("stall_rsp_data", rsp_data, 32'hC);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release_ready", cmd_ready, 1);
        check("stall_release_valid", rsp_valid, 0);
        cmd_valid = 1'b0;
        check("stall_no_write_mem2", mem[2], 0);

        // Reset between read_en and write_en of a set-bits RMW.
        @(negedge clk);
        rd_cnt = 0; wr_cnt = 0;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 5'd2; cmd_data = 32'h1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rmw_rst_read_issued", read_en, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rmw_rst_outputs",
              {rsp_valid, rsp_err, write_en, read_en, busy, (rsp_data == 0), (addr_word == 0), (wdata == 0)},
              {5'b0, 3'b111});
        rsp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) @(negedge clk);
        check("rmw_rst_no_write", wr_cnt, 0);
        check("rmw_rst_no_rsp", rsp_cnt, 0);
        check("rmw_rst_mem2", mem[2], 0);
        check("rmw_rst_cmd_ready", cmd_ready, 1);

        // Function resumes after reset.
        do_cmd(2'b00, 5'd1, '0, g_rsp, g_err, g_lat);
        check("post_rst_read_data", g_rsp, 32'hC);
        check("post_rst_read_lat", g_lat, 3);

        @(negedge clk);
        check("strobe_rule_violations", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/qar_mmio_initiator.md
Name: qar_mmio_initiator

Overview:
- Bus initiator for the QAR word-addressed peripheral register port: write_en, read_en, addr_word, wdata, rdata.
- Accepts register commands from a host-side valid/ready channel and sequences them onto the peripheral port, e.g. toward qar_gpio.
- Supports plain read, plain write and atomic read-modify-write (set-bits and clear-bits).
- Returns exactly one response per command on a valid/ready response channel.

Parameters:
- ADDR_W, 5, width of addr_word / cmd_addr.
- DATA_W, 32, data width.
- MAX_ADDR, 11, highest legal word address; commands above it are rejected.
- RD_LAT, 1, peripheral read latency in cycles, legal 0..3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  2  00 read, 01 write, 10 set-bits RMW, 11 clear-bits RMW.
- cmd_addr  in  ADDR_W  target word address.
- cmd_data  in  DATA_W  write data, or bit mask for RMW.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host consumes the response.
- rsp_data  out  DATA_W  response payload.
- rsp_err  out  1  address out of range.
- write_en  out  1  peripheral write strobe.
- read_en  out  1  peripheral read strobe.
- addr_word  out  ADDR_W  peripheral address.
- wdata  out  DATA_W  peripheral write data.
- rdata  in  DATA_W  peripheral read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, immediate): state IDLE. cmd_ready=1 once rst deasserts; rsp_valid=0, rsp_data=0, rsp_err=0, write_en=0, read_en=0, addr_word=0, wdata=0, busy=0.
- Reset mid-operation aborts the transaction with no response. Strobes drop asynchronously, so no partial RMW write is ever issued.
- All outputs are registered.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op, addr and data. Next state:
  - addr > MAX_ADDR -> RESP with rsp_err=1, rsp_data=0, no bus access.
  - op=01 -> WR_ISSUE.
  - otherwise -> RD_ISSUE.
- RD_ISSUE: read_en=1 and addr_word=latched address for exactly one cycle.
  - RD_LAT=0: rdata is captured at the edge ending this cycle.
  - RD_LAT>0: go to RD_WAIT.
- RD_WAIT: counts RD_LAT cycles. rdata is captured at the edge ending the RD_LAT-th cycle after the read_en cycle.
- After capture:
  - op=00 -> RESP with rsp_data=captured value.
  - op=10 -> WR_ISSUE with wdata=captured | mask.
  - op=11 -> WR_ISSUE with wdata=captured & ~mask.
- WR_ISSUE: write_en=1 for exactly one cycle with addr_word and wdata stable; then RESP.
  - rsp_data = written value for op=01.
  - rsp_data = old (captured) value for RMW.
- RESP: rsp_valid=1 with rsp_data and rsp_err held stable until rsp_ready. On rsp_valid&&rsp_ready, return to IDLE; the next command can be accepted the following cycle.
- cmd_ready=0 in every state except IDLE. At most one command is in flight.
- read_en and write_en are never high together, and each is never high for two consecutive cycles.
- addr_word and wdata hold their last values when no strobe is active.
- Latency with handshake at cycle T:
  - Write: write_en in cycle T+1, rsp_valid from T+2.
  - Read with RD_LAT=1: read_en in T+1, rsp_valid from T+3.
  - RMW with RD_LAT=1: read_en in T+1, write_en in T+3, rsp_valid from T+4.
- rsp_ready held high while idle has no effect. rsp_ready low stalls the FSM in RESP indefinitely.
- cmd_addr == MAX_ADDR is legal; MAX_ADDR+1 and above are errors.

Test Plan:
- Reset, then write addr 0 data 0x0000000F -> write_en pulse in T+1 with addr_word=0, wdata=0xF; rsp_valid in T+2 with rsp_data=0xF, rsp_err=0.
- Read addr 1 with the peripheral model returning 0x5 (RD_LAT=1) -> read_en in T+1; rsp_data=0x5 valid from T+3.
- Set-bits RMW addr 1, mask 0xA, current value 0x5 -> read, then write of 0xF; rsp_data=0x5. Clear-bits mask 0x3 afterwards -> write of 0xC; rsp_data=0xF.
- Command to addr 12 -> no read_en or write_en ever; rsp_err=1, rsp_data=0; a following legal command is accepted normally.
- Hold rsp_ready=0 for 5 cycles on a read response, with cmd_valid held high -> rsp_valid and rsp_data stable, cmd_ready=0 throughout; the handshake then releases to IDLE.
- Assert rst in the cycle between read_en and write_en of an RMW -> no write_en, no rsp_valid; all outputs at reset values immediately; cmd_ready=1 after release.
